// File: rtl/qpu_itcm_ctrl.sv
// qpu_itcm_ctrl
//   Shares the single-port QPU ITCM SRAM between the instruction fetch unit
//   (IFU, read-only) and the external host/download port (EXT, read/write).
//   Round-robin arbitration, one outstanding access, 1-cycle RAM read latency,
//   valid/ready responses, and automatic light-sleep after an idle period.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifu_cmd_*                  IFU read command (valid/ready, addr)
//   ifu_rsp_*                  IFU read response (valid/ready, rdata)
//   ext_cmd_*                  EXT command (valid/ready, read, addr, wdata, wmask)
//   ext_rsp_*                  EXT response (valid/ready, rdata; 0 for writes)
//   ram_cs/we/addr/wem/din     RAM command side
//   ram_dout                   RAM read data, valid the cycle after a read
//   ram_ls/ds/sd               RAM power controls (ds, sd tied low)
//   busy                       a transaction is outstanding
module qpu_itcm_ctrl #(
  parameter int AW      = 13,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int LS_IDLE = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,

  input  logic          ext_cmd_valid,
  output logic          ext_cmd_ready,
  input  logic          ext_cmd_read,
  input  logic [AW-1:0] ext_cmd_addr,
  input  logic [DW-1:0] ext_cmd_wdata,
  input  logic [MW-1:0] ext_cmd_wmask,
  output logic          ext_rsp_valid,
  input  logic          ext_rsp_ready,
  output logic [DW-1:0] ext_rsp_rdata,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd,

  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAKE = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [7:0] LS_LIMIT = 8'(LS_IDLE);
  localparam bit         LS_EN    = (LS_IDLE != 0);

  state_t     state_reg, state_next;
  logic       owner_ext_reg, owner_ext_next;  // 1 = EXT owns the pending response
  logic       rsp_rd_reg, rsp_rd_next;        // pending response carries read data
  logic       rr_ext_reg, rr_ext_next;        // 1 = EXT wins the next tie
  logic [7:0] idle_cnt_reg, idle_cnt_next;
  logic       ls_reg, ls_next;

  logic any_valid;
  logic owner_rsp_ready;
  logic grant_en;
  logic gnt_ext;
  logic gnt_ifu;
  logic rsp_active;

  assign any_valid       = ifu_cmd_valid | ext_cmd_valid;
  assign owner_rsp_ready = owner_ext_reg ? ext_rsp_ready : ifu_rsp_ready;

  // A new command may be accepted from IDLE when the RAM is awake, or in the
  // same cycle the pending response is taken (back-to-back). rst_n gates the
  // grant so no command is accepted while reset is held, even if requesters
  // keep their valids high.
  assign grant_en = rst_n &&
                    (((state_reg == ST_IDLE) && !ls_reg) ||
                     ((state_reg == ST_RSP) && owner_rsp_ready));

  assign gnt_ext = grant_en && ext_cmd_valid && (!ifu_cmd_valid || rr_ext_reg);
  assign gnt_ifu = grant_en && ifu_cmd_valid && !gnt_ext;

  assign ifu_cmd_ready = gnt_ifu;
  assign ext_cmd_ready = gnt_ext;

  assign ram_cs   = gnt_ifu | gnt_ext;
  assign ram_we   = gnt_ext & ~ext_cmd_read;
  assign ram_addr = gnt_ext ? ext_cmd_addr : ifu_cmd_addr;
  assign ram_din  = gnt_ext ? ext_cmd_wdata : '0;
  assign ram_wem  = gnt_ext ? ext_cmd_wmask : '0;
  assign ram_ls   = ls_reg;
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  // ram_cs stays low while a response waits, so ram_dout holds its value and
  // rdata is stable until the requester takes it.
  assign rsp_active    = (state_reg == ST_RSP);
  assign busy          = rsp_active;
  assign ifu_rsp_valid = rsp_active & ~owner_ext_reg;
  assign ext_rsp_valid = rsp_active & owner_ext_reg;
  assign ifu_rsp_rdata = ifu_rsp_valid ? ram_dout : '0;
  assign ext_rsp_rdata = (ext_rsp_valid && rsp_rd_reg) ? ram_dout : '0;

  always_comb begin
    state_next     = state_reg;
    owner_ext_next = owner_ext_reg;
    rsp_rd_next    = rsp_rd_reg;
    rr_ext_next    = rr_ext_reg;
    idle_cnt_next  = '0;
    ls_next        = 1'b0;

    if (ram_cs) begin
      state_next     = ST_RSP;
      owner_ext_next = gnt_ext;
      rsp_rd_next    = gnt_ifu | ext_cmd_read;
      // Prefer the requester that was not just served.
      rr_ext_next    = gnt_ifu;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Only reachable with a valid and no grant when the RAM is asleep.
          if (any_valid) begin
            state_next = ST_WAKE;
          end
        end
        ST_WAKE: state_next = ST_IDLE;
        ST_RSP: begin
          if (owner_rsp_ready) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Idle counter runs only in IDLE with no requests and saturates at the
    // limit; everything else clears it, which also drops ls for the wake.
    if ((state_reg == ST_IDLE) && !any_valid) begin
      idle_cnt_next = (idle_cnt_reg >= LS_LIMIT) ? LS_LIMIT : idle_cnt_reg + 8'd1;
    end
    ls_next = LS_EN && (idle_cnt_next == LS_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      owner_ext_reg <= 1'b0;
      rsp_rd_reg    <= 1'b0;
      rr_ext_reg    <= 1'b1;
      idle_cnt_reg  <= '0;
      ls_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_ext_reg <= owner_ext_next;
      rsp_rd_reg    <= rsp_rd_next;
      rr_ext_reg    <= rr_ext_next;
      idle_cnt_reg  <= idle_cnt_next;
      ls_reg        <= ls_next;
    end
  end

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// Testbench for qpu_itcm_ctrl: table of single transactions checked through a
// response scoreboard, plus hand-written sequences for arbitration, response
// back-pressure, light-sleep wake and reset during a pending response.
module tb_qpu_itcm_ctrl;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clk;
  logic          rst_n;
  logic          ifu_cmd_valid, ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid, ifu_rsp_ready;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
  logic [AW-1:0] ext_cmd_addr;
  logic [DW-1:0] ext_cmd_wdata;
  logic [MW-1:0] ext_cmd_wmask;
  logic          ext_rsp_valid, ext_rsp_ready;
  logic [DW-1:0] ext_rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_ls, ram_ds, ram_sd;
  logic          busy;

  qpu_itcm_ctrl #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
    .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds),
    .ram_sd(ram_sd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: byte-masked write, registered read that
  // holds its output when not selected for a read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++) begin
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] ifu_q[$];
  logic [DW-1:0] ext_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Response scoreboard plus always-true invariants.
  always @(negedge clk) begin
    if (ifu_rsp_valid && ifu_rsp_ready) begin
      if (ifu_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL ifu_rsp_unexpected actual=0x%h required=no response t=%0t", ifu_rsp_rdata, $time);
      end else begin
        check("ifu_rsp_rdata", ifu_rsp_rdata, ifu_q.pop_front());
      end
    end
    if (ext_rsp_valid && ext_rsp_ready) begin
      if (ext_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL ext_rsp_unexpected actual=0x%h required=no response t=%0t", ext_rsp_rdata, $time);
      end else begin
        check("ext_rsp_rdata", ext_rsp_rdata, ext_q.pop_front());
      end
    end
    if (rst_n) begin
      check("ls_with_cs", ram_ls & ram_cs, 0);
      check("dual_rsp_valid", ifu_rsp_valid & ext_rsp_valid, 0);
      check("ds_sd_tied", {ram_ds, ram_sd}, 0);
    end
  end

  typedef struct {
    bit            is_ext;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  task automatic wait_ready(input bit is_ext, output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if ((is_ext ? ext_cmd_ready : ifu_cmd_ready) === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL cmd_ready_timeout actual=no grant required=grant port=%s t=%0t",
               is_ext ? "ext" : "ifu", $time);
    end
  endtask

  task automatic issue(input vec_t v);
    bit got;
    @(posedge clk); #1;
    if (v.is_ext) begin
      ext_cmd_valid = 1'b1; ext_cmd_read = v.rd; ext_cmd_addr = v.addr;
      ext_cmd_wdata = v.wdata; ext_cmd_wmask = v.wmask;
      ext_q.push_back(v.exp);
    end else begin
      ifu_cmd_valid = 1'b1; ifu_cmd_addr = v.addr;
      ifu_q.push_back(v.exp);
    end
    wait_ready(v.is_ext, got);
    if (got) begin
      check("hs_ram_cs", ram_cs, 1);
      check("hs_ram_we", ram_we, v.is_ext && !v.rd);
      check("hs_ram_addr", ram_addr, v.addr);
      check("hs_ram_wem", ram_wem, v.is_ext ? v.wmask : 8'h00);
      if (v.is_ext && !v.rd) check("hs_ram_din", ram_din, v.wdata);
    end
    @(posedge clk); #1;
    ifu_cmd_valid = 1'b0;
    ext_cmd_valid = 1'b0;
    if (got) begin
      @(negedge clk);
      check("rsp_latency", v.is_ext ? ext_rsp_valid : ifu_rsp_valid, 1);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && (ifu_q.size() != 0 || ext_q.size() != 0); n++) @(negedge clk);
    if (ifu_q.size() != 0 || ext_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=ifu:%0d ext:%0d pending required=0", ifu_q.size(), ext_q.size());
      ifu_q.delete();
      ext_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    vecs[0]  = '{1'b1, 1'b0, 13'h010,  64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 13'h010,  64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[2]  = '{1'b1, 1'b0, 13'h020,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 13'h020,  64'h0011_2233_4455_6677, 8'h0F, 64'h0};
    vecs[4]  = '{1'b1, 1'b1, 13'h020,  64'h0, 8'h00, 64'hFFFF_FFFF_4455_6677};
    vecs[5]  = '{1'b0, 1'b1, 13'h020,  64'h0, 8'h00, 64'hFFFF_FFFF_4455_6677};
    vecs[6]  = '{1'b1, 1'b0, 13'h1FFF, 64'hA5A5_A5A5_A5A5_A5A5, 8'h81, 64'h0};
    vecs[7]  = '{1'b1, 1'b1, 13'h1FFF, 64'h0, 8'h00, 64'hA500_0000_0000_00A5};
    vecs[8]  = '{1'b0, 1'b1, 13'h000,  64'h0, 8'h00, 64'h0};
    vecs[9]  = '{1'b1, 1'b0, 13'h010,  64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'h0};
    vecs[10] = '{1'b0, 1'b1, 13'h010,  64'h0, 8'h00, 64'hDEAD_BEEF_89AB_CDEF};

    rst_n = 1'b0;
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = '0;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = '0;
    ext_cmd_wdata = '0; ext_cmd_wmask = '0;
    ifu_rsp_ready = 1'b1; ext_rsp_ready = 1'b1;

    // Reset state, with requests held high to show nothing is accepted.
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {ifu_cmd_ready, ext_cmd_ready, ifu_rsp_valid, ext_rsp_valid, ram_cs, ram_we, busy, ram_ls}, 0);
    ifu_cmd_valid = 1'b0;
    ext_cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single transactions.
    for (int i = 0; i < NVEC; i++) begin
      $display("vec %0d: %s %s addr=0x%h exp=0x%h", i, vecs[i].is_ext ? "ext" : "ifu",
               vecs[i].rd ? "rd" : "wr", vecs[i].addr, vecs[i].exp);
      issue(vecs[i]);
    end
    drain();

    // Both ports requesting every cycle: EXT first after reset, then alternate.
    do_reset();
    @(posedge clk); #1;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 13'h020;
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("alt_ext_ready", ext_cmd_ready, (i % 2) == 0);
      check("alt_ifu_ready", ifu_cmd_ready, (i % 2) == 1);
      check("alt_ram_cs", ram_cs, 1);
      if ((i % 2) == 0) ext_q.push_back(64'hFFFF_FFFF_4455_6677);
      else              ifu_q.push_back(64'hDEAD_BEEF_89AB_CDEF);
      $display("alt cycle %0d: expect %s grant", i, (i % 2) == 0 ? "ext" : "ifu");
      @(posedge clk); #1;
    end
    ext_cmd_valid = 1'b0;
    ifu_cmd_valid = 1'b0;
    drain();

    // IFU response back-pressure for 5 cycles with EXT waiting.
    @(posedge clk); #1;
    ifu_rsp_ready = 1'b0;
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h010;
    ifu_q.push_back(64'hDEAD_BEEF_89AB_CDEF);
    wait_ready(1'b0, got);
    @(posedge clk); #1;
    ifu_cmd_valid = 1'b0;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 13'h020;
    ext_q.push_back(64'hFFFF_FFFF_4455_6677);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ifu_rsp_valid", ifu_rsp_valid, 1);
      check("stall_ifu_rdata", ifu_rsp_rdata, 64'hDEAD_BEEF_89AB_CDEF);
      check("stall_ram_cs", ram_cs, 0);
      check("stall_ext_ready", ext_cmd_ready, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    ifu_rsp_ready = 1'b1;
    @(negedge clk);
    check("release_ext_grant", ext_cmd_ready, 1);
    check("release_ram_cs", ram_cs, 1);
    @(posedge clk); #1;
    ext_cmd_valid = 1'b0;
    drain();
    $display("stall sequence done");

    // Light sleep after 4 idle cycles, then wake for an IFU read.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("ls_idle_count", ram_ls, k >= 4);
    end
    @(posedge clk); #1;
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h020;
    ifu_q.push_back(64'hFFFF_FFFF_4455_6677);
    @(negedge clk);
    check("ls_req_ls", ram_ls, 1);
    check("ls_req_ready", ifu_cmd_ready, 0);
    @(negedge clk);
    check("wake_ls", ram_ls, 0);
    check("wake_ready", ifu_cmd_ready, 0);
    check("wake_cs", ram_cs, 0);
    @(negedge clk);
    check("post_wake_ready", ifu_cmd_ready, 1);
    check("post_wake_cs", ram_cs, 1);
    @(posedge clk); #1;
    ifu_cmd_valid = 1'b0;
    drain();
    $display("light sleep sequence done");

    // Reset while a response is pending.
    @(posedge clk); #1;
    ext_rsp_ready = 1'b0;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 13'h010;
    wait_ready(1'b1, got);
    @(posedge clk); #1;
    ext_cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ext_rsp_valid", ext_rsp_valid, 1);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {ext_rsp_valid, ifu_rsp_valid, busy, ram_cs}, 0);
    ext_rsp_ready = 1'b1;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 13'h020;
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h010;
    @(negedge clk);
    check("in_rst_cs", ram_cs, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ext_grant", ext_cmd_ready, 1);
    check("post_rst_ifu_wait", ifu_cmd_ready, 0);
    ext_q.push_back(64'hFFFF_FFFF_4455_6677);
    @(posedge clk); #1;
    ext_cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ifu_grant", ifu_cmd_ready, 1);
    ifu_q.push_back(64'hDEAD_BEEF_89AB_CDEF);
    @(posedge clk); #1;
    ifu_cmd_valid = 1'b0;
    drain();
    $display("reset sequence done");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
